// File: rtl/tree_multiplier.sv
// Unsigned SIZE x SIZE multiplier built from a carry-save reduction tree.
// AND-array partial products are compressed with banks of full adders (3:2)
// until two rows remain, then summed by one carry-propagate adder into the
// registered product c. over flags a product wider than SIZE bits.
// Build option: define TREE_MULTIPLIER_PIPE_EN to register the two tree
// output rows ahead of the final adder (latency 2 instead of 1).
module tree_multiplier #(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              over,
    output logic [2*SIZE-1:0] c
);

    localparam int W = 2 * SIZE;

    // Rows remaining after lvl reduction levels: each complete group of
    // three rows becomes a sum row and a carry row, leftovers pass through.
    function automatic int rows_after(input int lvl);
        int r;
        r = SIZE;
        for (int i = 0; i < lvl; i++) begin
            r = 2 * (r / 3) + (r % 3);
        end
        return r;
    endfunction

    function automatic int num_levels();
        int r;
        int n;
        r = SIZE;
        n = 0;
        while (r > 2) begin
            r = 2 * (r / 3) + (r % 3);
            n++;
        end
        return n;
    endfunction

    localparam int NLEV = num_levels();

    logic [W-1:0] pp [SIZE];
    logic [W-1:0] row_x;
    logic [W-1:0] row_y;
    logic [W-1:0] sum_d;
    logic [W-1:0] c_d;
    logic         over_d;
    logic [W-1:0] c_q;
    logic         over_q;

    // Partial product row j is a gated by b[j], weighted by 2^j.
    for (genvar j = 0; j < SIZE; j++) begin : g_pp
        assign pp[j] = W'(a & {SIZE{b[j]}}) << j;
    end

    // Each level is a separate generate scope so the rows of one level never
    // share a variable with the rows that feed it.
    for (genvar l = 0; l < NLEV; l++) begin : g_lvl
        localparam int R  = rows_after(l);
        localparam int G  = R / 3;
        localparam int RN = rows_after(l + 1);

        logic [W-1:0] rin  [R];
        logic [W-1:0] rout [RN];

        if (l == 0) begin : g_src_pp
            assign rin = pp;
        end else begin : g_src_lvl
            assign rin = g_lvl[l-1].rout;
        end

        // Full adder per column: sum stays in place, carry moves one column
        // up. The carry out of the top column is dropped; the product always
        // fits in W bits so the arithmetic is exact modulo 2^W.
        for (genvar g = 0; g < G; g++) begin : g_csa
            assign rout[2*g]   = rin[3*g] ^ rin[3*g+1] ^ rin[3*g+2];
            assign rout[2*g+1] = ((rin[3*g]   & rin[3*g+1]) |
                                  (rin[3*g]   & rin[3*g+2]) |
                                  (rin[3*g+1] & rin[3*g+2])) << 1;
        end

        for (genvar p = 0; p < R - 3 * G; p++) begin : g_pass
            assign rout[2*G+p] = rin[3*G+p];
        end
    end

    if (NLEV == 0) begin : g_rows_pp
        assign row_x = pp[0];
        assign row_y = pp[1];
    end else begin : g_rows_tree
        assign row_x = g_lvl[NLEV-1].rout[0];
        assign row_y = g_lvl[NLEV-1].rout[1];
    end

`ifdef TREE_MULTIPLIER_PIPE_EN
    logic [W-1:0] row_x_q;
    logic [W-1:0] row_y_q;

    // Pipeline stage between the reduction tree and the final adder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_x_q <= '0;
            row_y_q <= '0;
        end else begin
            row_x_q <= row_x;
            row_y_q <= row_y;
        end
    end

    assign sum_d = row_x_q + row_y_q;
`else
    assign sum_d = row_x + row_y;
`endif

    // over is derived from the same sum that is loaded into c, so the two
    // outputs can never disagree.
    always_comb begin
        c_d    = sum_d;
        over_d = |sum_d[W-1:SIZE];
    end

    // Output register: loads every cycle, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q    <= '0;
            over_q <= 1'b0;
        end else begin
            c_q    <= c_d;
            over_q <= over_d;
        end
    end

    assign c    = c_q;
    assign over = over_q;

endmodule

// File: tb/tb_tree_multiplier.sv
// Bench for tree_multiplier: three instances (SIZE 2, 4, 8) driven in
// lockstep, checked every cycle against a history-based product model, plus
// directed boundary vectors with fixed expected values.
module tb_tree_multiplier;

`ifdef TREE_MULTIPLIER_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  a2, b2;
    logic [3:0]  a4, b4;
    logic [7:0]  a8, b8;
    logic [3:0]  c2;
    logic [7:0]  c4;
    logic [15:0] c8;
    logic        o2, o4, o8;

    always #5 clk = ~clk;

    tree_multiplier #(.SIZE(2)) u_m2 (.clk(clk), .rst_n(rst_n), .a(a2), .b(b2), .over(o2), .c(c2));
    tree_multiplier #(.SIZE(4)) u_m4 (.clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .over(o4), .c(c4));
    tree_multiplier #(.SIZE(8)) u_m8 (.clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .over(o8), .c(c8));

    typedef struct {
        bit          rst_ok;
        int unsigned p2;
        int unsigned p4;
        int unsigned p8;
    } hist_t;

    typedef struct {
        bit          has;
        int unsigned c2;
        bit          o2;
        int unsigned c8;
        bit          o8;
    } kexp_t;

    hist_t hist[$];
    kexp_t kq[$];
    int    tests = 0;
    int    fails = 0;

    // Output after the latest edge is the product sampled LAT edges back,
    // unless any edge in that window was a reset edge.
    function automatic int unsigned model_c(input int sz);
        int n;
        n = hist.size();
        if (n < LAT) return 0;
        for (int i = n - LAT; i < n; i++) begin
            if (!hist[i].rst_ok) return 0;
        end
        case (sz)
            2:       return hist[n-LAT].p2;
            4:       return hist[n-LAT].p4;
            default: return hist[n-LAT].p8;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic r,
                        input logic [1:0] xa2, input logic [1:0] xb2,
                        input logic [3:0] xa4, input logic [3:0] xb4,
                        input logic [7:0] xa8, input logic [7:0] xb8,
                        input bit has,
                        input int unsigned k2, input bit ko2,
                        input int unsigned k8, input bit ko8);
        hist_t       h;
        kexp_t       k;
        int unsigned e;
        rst_n = r;
        a2 = xa2; b2 = xb2;
        a4 = xa4; b4 = xb4;
        a8 = xa8; b8 = xb8;
        @(posedge clk);
        h.rst_ok = r;
        h.p2 = 32'(xa2) * 32'(xb2);
        h.p4 = 32'(xa4) * 32'(xb4);
        h.p8 = 32'(xa8) * 32'(xb8);
        hist.push_back(h);
        #1;
        e = model_c(2);
        chk("c2", 32'(c2), e);
        chk("over2", 32'(o2), 32'((e >> 2) != 0));
        e = model_c(4);
        chk("c4", 32'(c4), e);
        chk("over4", 32'(o4), 32'((e >> 4) != 0));
        e = model_c(8);
        chk("c8", 32'(c8), e);
        chk("over8", 32'(o8), 32'((e >> 8) != 0));
        if (!r) begin
            kq.delete();
            chk("rst_c2", 32'(c2), 32'd0);
            chk("rst_over8", 32'(o8), 32'd0);
            chk("rst_c8", 32'(c8), 32'd0);
        end else begin
            k.has = has; k.c2 = k2; k.o2 = ko2; k.c8 = k8; k.o8 = ko8;
            kq.push_back(k);
            if (kq.size() >= LAT) begin
                k = kq.pop_front();
                if (k.has) begin
                    chk("dir_c2", 32'(c2), k.c2);
                    chk("dir_over2", 32'(o2), 32'(k.o2));
                    chk("dir_c8", 32'(c8), k.c8);
                    chk("dir_over8", 32'(o8), 32'(k.o8));
                end
            end
        end
    endtask

    task automatic rnd_step(input logic r);
        step(r, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
             4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
             8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
             1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int unsigned e8;

        // Reset held for two edges with all-ones operands.
        step(1'b0, 2'd3, 2'd3, 4'd15, 4'd15, 8'd255, 8'd255, 1'b0, 0, 1'b0, 0, 1'b0);
        step(1'b0, 2'd3, 2'd3, 4'd15, 4'd15, 8'd255, 8'd255, 1'b0, 0, 1'b0, 0, 1'b0);
        step(1'b1, 2'd3, 2'd3, 4'd15, 4'd15, 8'd255, 8'd255, 1'b1, 9, 1'b1, 16'hFE01, 1'b1);
        rnd_step(1'b1);
        rnd_step(1'b1);

        // Directed boundary vectors, back to back.
        step(1'b1, 2'd3, 2'd0, 4'd0, 4'd0, 8'd0,   8'd255, 1'b1, 0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 2'd3, 2'd1, 4'd5, 4'd3, 8'd15,  8'd17,  1'b1, 3, 1'b0, 16'h00FF, 1'b0);
        step(1'b1, 2'd3, 2'd2, 4'd8, 4'd2, 8'd16,  8'd16,  1'b1, 6, 1'b1, 16'h0100, 1'b1);
        step(1'b1, 2'd3, 2'd3, 4'd15, 4'd15, 8'd255, 8'd255, 1'b1, 9, 1'b1, 16'hFE01, 1'b1);
        rnd_step(1'b1);
        rnd_step(1'b1);

        // Reset pulse between edges must not disturb the registered outputs.
        e8 = model_c(8);
        rst_n = 1'b0;
        #2;
        chk("rst_between_edges_c8", 32'(c8), e8);
        rst_n = 1'b1;

        // Reset for one edge in the middle of a stream.
        rnd_step(1'b1);
        rnd_step(1'b1);
        rnd_step(1'b1);
        rnd_step(1'b0);
        for (int i = 0; i < 5; i++) rnd_step(1'b1);

        // Random back-to-back traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rnd_step(($urandom_range(39, 0) == 0) ? 1'b0 : 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
